// File: rtl/emg_stream_burst_ctrl.sv
// emg_stream_burst_ctrl: packetises a free-running ADC sample stream
// into AXI-Stream bursts through a one-entry output register.
// Ports:
//   ACLK, ARESETN           clock, async active-low reset
//   start, stop             arm / gracefully end an acquisition
//   cfg_burst_len           beats per packet (0 treated as 1)
//   cfg_num_bursts          packets per acquisition (0 = until stop)
//   sample_data/valid       ADC input, no backpressure
//   m_axis_tdata/tvalid/
//   m_axis_tready/tlast     stream output toward the DMA
//   busy, done, overflow    status
//   burst_count, drop_count packets completed / samples dropped
module emg_stream_burst_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  start,
   input  logic                  stop,
   input  logic [CNT_WIDTH-1:0]  cfg_burst_len,
   input  logic [CNT_WIDTH-1:0]  cfg_num_bursts,
   input  logic [DATA_WIDTH-1:0] sample_data,
   input  logic                  sample_valid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [CNT_WIDTH-1:0]  burst_count,
   output logic [CNT_WIDTH-1:0]  drop_count
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t state, state_n;

   logic [1:0]           rst_sync;
   logic                 rst_n;
   logic [CNT_WIDTH-1:0] len_q;
   logic [CNT_WIDTH-1:0] num_q;
   logic [CNT_WIDTH-1:0] beat_q;
   logic                 stop_pend;

   logic                 hs;
   logic                 hs_last;
   logic                 in_stream;
   logic                 last_beat;
   logic                 stop_req;
   logic                 stop_now;
   logic                 load;
   logic                 drop;
   logic [CNT_WIDTH:0]   bursts_after;
   logic                 num_hit;
   logic                 to_drain;
   logic                 arm;

   // Assert asynchronously, release on the second clock edge.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   assign hs        = m_axis_tvalid & m_axis_tready;
   assign hs_last   = hs & m_axis_tlast;
   assign in_stream = (state == STREAM);
   assign arm       = (state == IDLE) & start;
   assign last_beat = (beat_q == len_q - CNT_ONE);
   assign stop_req  = stop | stop_pend;

   // Clean stop point: no partial packet counted and nothing held.
   assign stop_now = in_stream & stop_req
                   & (beat_q == '0) & ~m_axis_tvalid;

   assign load = in_stream & sample_valid
               & (~m_axis_tvalid | hs) & ~stop_now;
   assign drop = in_stream & sample_valid
               & m_axis_tvalid & ~hs;

   // Packets complete once the beat being loaded has gone out,
   // including a tlast beat handshaking in this same cycle.
   assign bursts_after = {1'b0, burst_count}
                       + {{CNT_WIDTH{1'b0}}, hs_last}
                       + {{CNT_WIDTH{1'b0}}, 1'b1};
   assign num_hit  = (num_q != '0)
                   & (bursts_after == {1'b0, num_q});
   assign to_drain = load & last_beat & (stop_req | num_hit);

   always_ff @(posedge ACLK or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_n = STREAM;
         end
         STREAM: begin
            busy = 1'b1;
            if (to_drain)      state_n = DRAIN;
            else if (stop_now) state_n = DONE;
         end
         DRAIN: begin
            busy = 1'b1;
            if (hs_last) state_n = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge rst_n) begin
      if (!rst_n) begin
         len_q       <= CNT_ONE;
         num_q       <= '0;
         beat_q      <= '0;
         burst_count <= '0;
         drop_count  <= '0;
         overflow    <= 1'b0;
         stop_pend   <= 1'b0;
      end else if (arm) begin
         len_q       <= (cfg_burst_len == '0) ? CNT_ONE
                                              : cfg_burst_len;
         num_q       <= cfg_num_bursts;
         beat_q      <= '0;
         burst_count <= '0;
         drop_count  <= '0;
         overflow    <= 1'b0;
         stop_pend   <= 1'b0;
      end else begin
         if (load)
            beat_q <= last_beat ? '0 : beat_q + CNT_ONE;
         if (hs_last)
            burst_count <= burst_count + CNT_ONE;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1)
               drop_count <= drop_count + CNT_ONE;
         end
         if (in_stream & stop)
            stop_pend <= 1'b1;
         if (to_drain | stop_now)
            stop_pend <= 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else if (load) begin
         m_axis_tdata  <= sample_data;
         m_axis_tlast  <= last_beat;
         m_axis_tvalid <= 1'b1;
      end else if (hs) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: doc/emg_stream_burst_ctrl.md
EMG_STREAM_BURST_CTRL -- requirements
Module: emg_stream_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of sample data and stream data.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the beat, burst and drop counters.
REQ-003 SHALL have one clock and one reset: the reset is asynchronous and active-low, and the ports are named ACLK and ARESETN.
REQ-004 ACLK  in  1  clock; all logic on the rising edge.
REQ-005 ARESETN  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse that arms an acquisition; honoured only in IDLE.
REQ-007 stop  in  1  one-cycle pulse requesting graceful termination; honoured only in STREAM.
REQ-008 cfg_burst_len  in  CNT_WIDTH  beats per packet; 0 SHALL be treated as 1.
REQ-009 cfg_num_bursts  in  CNT_WIDTH  packets per acquisition; 0 means continuous until stop.
REQ-010 sample_data  in  DATA_WIDTH  ADC sample; the source has no backpressure.
REQ-011 sample_valid  in  1  sample_data is valid this cycle.
REQ-012 m_axis_tdata  out  DATA_WIDTH  stream data toward the DMA.
REQ-013 m_axis_tvalid  out  1  stream beat valid.
REQ-014 m_axis_tready  in  1  DMA accepts the beat.
REQ-015 m_axis_tlast  out  1  last beat of a packet.
REQ-016 busy  out  1  high in STREAM and DRAIN.
REQ-017 done  out  1  one-cycle pulse on acquisition end.
REQ-018 overflow  out  1  sticky flag set when a sample is dropped; cleared only by start or reset.
REQ-019 burst_count  out  CNT_WIDTH  packets completed in the current acquisition.
REQ-020 drop_count  out  CNT_WIDTH  samples dropped in the current acquisition; saturates at all-ones.

Function
REQ-021 The FSM states SHALL be IDLE, STREAM, DRAIN and DONE.
REQ-022 IDLE -> STREAM on start; the block SHALL latch cfg_burst_len and cfg_num_bursts, clear burst_count, drop_count, overflow and the beat counter.
REQ-023 Changes to the cfg_* inputs SHALL have no effect outside the start cycle.
REQ-024 The output SHALL be a one-entry register (data, tlast, valid); m_axis_tvalid comes from the register, with no combinational path from the inputs.
REQ-025 In STREAM, a sample SHALL load when sample_valid is asserted and the register is empty or handshaking (tvalid & tready) in the same cycle; tvalid then stays 1 with no bubble.
REQ-026 A sample arriving while the register is full and not handshaking SHALL be dropped: overflow is set, drop_count increments, and the beat counter is unchanged.
REQ-027 On each load, the beat counter increments and the stored tlast is (beat counter == latched_len-1); after a tlast load, the beat counter returns to 0.
REQ-028 burst_count SHALL increment on each handshake of a tlast beat.
REQ-029 STREAM -> DRAIN when a tlast beat loads and either a stop is pending or burst_count+1 (counting the held beat) equals a nonzero latched_num_bursts.
REQ-030 A stop with the beat counter at 0 and the register empty SHALL cause STREAM -> DONE next cycle; otherwise the stop is held pending until the current packet's tlast beat loads.
REQ-031 In DRAIN, no samples load and none count as dropped; DRAIN -> DONE on the tlast handshake.
REQ-032 DONE SHALL assert done for exactly one cycle, then go to IDLE; burst_count and drop_count hold until the next start.
REQ-033 In IDLE and DONE, sample_valid SHALL be ignored (no load, no overflow); start is ignored outside IDLE, and stop is ignored outside STREAM.
REQ-034 Simultaneous stop and tlast load SHALL take the DRAIN path.
REQ-035 m_axis_tdata and m_axis_tlast SHALL remain stable while tvalid=1 and tready=0.

Reset
REQ-036 Asserting ARESETN=0 at any time, including mid-packet, SHALL force IDLE and clear the register, tvalid, tlast, busy, done, overflow, both counters and the pending stop; a partial packet is discarded.
REQ-037 Reset deassertion SHALL be synchronised to ACLK internally, so the first state change occurs no earlier than the second rising edge after release.

Verification
REQ-038 len=4, num=2, tready=1, one sample per cycle 1..8 -> 8 beats, tlast on data 4 and 8, burst_count=2, one-cycle done, overflow=0.
REQ-039 len=4, num=1, tready=0 for 3 cycles while samples 1..4 arrive each cycle -> beat 1 held stable, samples 2..4 dropped, drop_count=3, overflow=1, burst still completes with later samples.
REQ-040 len=3, num=0, stop after 4 loaded beats -> packet 2 completes (6 beats), DRAIN then done, burst_count=2.
REQ-041 len=0, num=3 -> every beat has tlast, 3 beats total, burst_count=3.
REQ-042 ARESETN pulled low mid-packet with tvalid=1 -> tvalid=0 and counters=0 immediately; a fresh start works normally.
REQ-043 stop in the same cycle as a tlast load, with tready=0 for 2 cycles -> DRAIN holds the beat, then done after the handshake, and no further loads occur.
